// File: rtl/cmp_pkg.sv
// Shared types and constants for the integer/FP compare unit.
package cmp_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned EXT_W = 64;

  typedef enum logic [OP_W-1:0] {
    CMP_INT = 3'd0,
    FEQ     = 3'd1,
    FLT     = 3'd2,
    FLE     = 3'd3,
    FMIN    = 3'd4,
    FMAX    = 3'd5
  } cmp_op_e;

  typedef enum logic {
    FMT_S = 1'b0,
    FMT_D = 1'b1
  } cmp_fmt_e;

  localparam logic [EXT_W-1:0] CNAN_S = 64'hFFFF_FFFF_7FC0_0000;
  localparam logic [EXT_W-1:0] CNAN_D = 64'h7FF8_0000_0000_0000;

  typedef struct packed {
    logic is_nan;
    logic is_snan;
    logic is_zero;
    logic sign;
  } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Format-aware FP operand classifier; an unboxed single reads as canonical qNaN.
module fp_classify
  import cmp_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0] val,
  input  logic              fmt,
  output fp_class_t         cls_c
);

  logic [EXT_W-1:0] v;
  logic             boxed;

  // Decode sign/exponent/mantissa fields for the selected format
  always_comb begin
    v     = EXT_W'(val);
    boxed = (DATA_W == 32) || (v[63:32] == '1);
    cls_c = '0;
    if (fmt == FMT_S) begin
      if (!boxed) begin
        cls_c.is_nan = 1'b1;
      end else begin
        cls_c.sign    = v[31];
        cls_c.is_nan  = (v[30:23] == '1) && (v[22:0] != '0);
        cls_c.is_snan = (v[30:23] == '1) && (v[22:0] != '0) && !v[22];
        cls_c.is_zero = (v[30:0] == '0);
      end
    end else begin
      cls_c.sign    = v[63];
      cls_c.is_nan  = (v[62:52] == '1) && (v[51:0] != '0);
      cls_c.is_snan = (v[62:52] == '1) && (v[51:0] != '0) && !v[51];
      cls_c.is_zero = (v[62:0] == '0);
    end
  end

endmodule

// File: rtl/compare_unit.sv
// Two-stage integer / IEEE-754 compare and min/max unit with valid/ready and flush.
module compare_unit
  import cmp_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter bit          FP_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [OP_W-1:0]   op_i,
  input  logic              fmt_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              eq_o,
  output logic              lt_s_o,
  output logic              lt_u_o,
  output logic              nv_o
);

  logic              s1_valid;
  logic [OP_W-1:0]   s1_op;
  logic              s1_fmt;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  fp_class_t         s1_ca;
  fp_class_t         s1_cb;
  fp_class_t         ca_c;
  fp_class_t         cb_c;

  logic s2_load;
  logic s1_adv;
  logic accept;

  fp_classify #(.DATA_W(DATA_W)) u_cls_a (.val(a_i), .fmt(fmt_i), .cls_c(ca_c));
  fp_classify #(.DATA_W(DATA_W)) u_cls_b (.val(b_i), .fmt(fmt_i), .cls_c(cb_c));

  assign s2_load    = !out_valid_o || out_ready_i;
  assign s1_adv     = s2_load;
  assign in_ready_o = (!s1_valid || s1_adv) && !flush_i;
  assign accept     = in_valid_i && in_ready_o;

  logic [DATA_W-1:0] res_c;
  logic              eq_c, lt_s_c, lt_u_c, nv_c;
  logic [EXT_W-1:0]  a64, b64, sel64;
  logic [62:0]       ma, mb;
  logic              both_zero, any_nan, any_snan, a_lt_b, feq_c, flt_c, fp_bad;

  // Stage-2 result computation from the captured operands and classes
  always_comb begin
    a64       = EXT_W'(s1_a);
    b64       = EXT_W'(s1_b);
    ma        = (s1_fmt == FMT_D) ? a64[62:0] : 63'(a64[30:0]);
    mb        = (s1_fmt == FMT_D) ? b64[62:0] : 63'(b64[30:0]);
    both_zero = s1_ca.is_zero && s1_cb.is_zero;
    any_nan   = s1_ca.is_nan || s1_cb.is_nan;
    any_snan  = s1_ca.is_snan || s1_cb.is_snan;
    // Sign-magnitude total order where -0 sorts below +0
    a_lt_b    = (s1_ca.sign != s1_cb.sign) ? s1_ca.sign
              : (s1_ca.sign ? (ma > mb) : (ma < mb));
    feq_c     = !any_nan && (both_zero || ((s1_ca.sign == s1_cb.sign) && (ma == mb)));
    flt_c     = !any_nan && !both_zero && a_lt_b;
    fp_bad    = !FP_EN || ((s1_fmt == FMT_D) && (DATA_W == 32));
    sel64     = '0;
    res_c     = '0;
    eq_c      = 1'b0;
    lt_s_c    = 1'b0;
    lt_u_c    = 1'b0;
    nv_c      = 1'b0;
    case (s1_op)
      CMP_INT: begin
        eq_c   = (s1_a == s1_b);
        lt_u_c = (s1_a < s1_b);
        lt_s_c = ($signed(s1_a) < $signed(s1_b));
        res_c  = DATA_W'(lt_s_c);
      end
      FEQ: begin
        res_c = DATA_W'(feq_c);
        nv_c  = any_snan;
      end
      FLT: begin
        res_c = DATA_W'(flt_c);
        nv_c  = any_nan;
      end
      FLE: begin
        res_c = DATA_W'(flt_c || feq_c);
        nv_c  = any_nan;
      end
      FMIN, FMAX: begin
        nv_c = any_snan;
        if (s1_ca.is_nan && s1_cb.is_nan) sel64 = (s1_fmt == FMT_D) ? CNAN_D : CNAN_S;
        else if (s1_ca.is_nan)            sel64 = b64;
        else if (s1_cb.is_nan)            sel64 = a64;
        else sel64 = ((s1_op == FMIN) == a_lt_b) ? a64 : b64;
        if (s1_fmt == FMT_S) sel64[63:32] = '1;
        res_c = DATA_W'(sel64);
      end
      default: ;
    endcase
    if (fp_bad && (s1_op != CMP_INT) && (s1_op <= FMAX)) begin
      res_c = '0;
      nv_c  = 1'b1;
    end
  end

  // Stage 1: capture operands, op and operand classes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_fmt   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_ca    <= '0;
      s1_cb    <= '0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else begin
      if (!s1_valid || s1_adv) s1_valid <= in_valid_i;
      if (accept) begin
        s1_op  <= op_i;
        s1_fmt <= fmt_i;
        s1_a   <= a_i;
        s1_b   <= b_i;
        s1_ca  <= ca_c;
        s1_cb  <= cb_c;
      end
    end
  end

  // Stage 2: registered result, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      result_o    <= '0;
      eq_o        <= 1'b0;
      lt_s_o      <= 1'b0;
      lt_u_o      <= 1'b0;
      nv_o        <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (s2_load) begin
      out_valid_o <= s1_valid;
      if (s1_valid) begin
        result_o <= res_c;
        eq_o     <= eq_c;
        lt_s_o   <= lt_s_c;
        lt_u_o   <= lt_u_c;
        nv_o     <= nv_c;
      end
    end
  end

endmodule

// File: tb/tb_compare_unit.sv
// Scoreboard bench for compare_unit: real-valued FP reference model, randomized stimulus.
module tb_compare_unit;

  localparam int unsigned DW = 64;
  localparam logic [63:0] QNAN_S = 64'hFFFF_FFFF_7FC0_0000;
  localparam logic [63:0] QNAN_D = 64'h7FF8_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [2:0]    op_i = '0;
  logic          fmt_i = 1'b0;
  logic [DW-1:0] a_i = '0;
  logic [DW-1:0] b_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [DW-1:0] result_o;
  logic          eq_o, lt_s_o, lt_u_o, nv_o;

  compare_unit #(.DATA_W(DW), .FP_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .fmt_i(fmt_i), .a_i(a_i), .b_i(b_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .eq_o(eq_o), .lt_s_o(lt_s_o), .lt_u_o(lt_u_o), .nv_o(nv_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] res;
    logic eq;
    logic lts;
    logic ltu;
    logic nv;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   out_count = 0;
  int   n_accepted = 0;
  bit   rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] r, input logic eq, input logic lts,
                              input logic ltu, input logic nv);
    exp_t e;
    e.res = r; e.eq = eq; e.lts = lts; e.ltu = ltu; e.nv = nv;
    return e;
  endfunction

  // Turn an operand into (nan, snan, real value, sign) for the chosen format
  function automatic void decode(input logic [63:0] x, input logic fmt, output bit nan,
                                 output bit snan, output real v, output bit sgn);
    int e, m;
    if (fmt == 1'b0) begin
      if (x[63:32] != 32'hFFFF_FFFF) begin
        nan = 1; snan = 0; v = 0.0; sgn = 0;
        return;
      end
      sgn  = x[31];
      e    = int'(x[30:23]);
      m    = int'(x[22:0]);
      nan  = (e == 255) && (m != 0);
      snan = nan && !x[22];
      if (e == 255)    v = $bitstoreal(64'h7FF0_0000_0000_0000);
      else if (e == 0) v = real'(m) * (2.0 ** (-149.0));
      else             v = (real'(m) + 8388608.0) * (2.0 ** (real'(e) - 150.0));
      if (sgn) v = -v;
    end else begin
      sgn  = x[63];
      nan  = (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
      snan = nan && !x[51];
      v    = $bitstoreal(x);
    end
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic fmt,
                                 input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    bit an, as, asg, bn, bs, bsg, a_less, b_less;
    real av, bv;
    e = '0;
    if (op == 3'd0) begin
      e.eq  = (a == b);
      e.ltu = (a < b);
      e.lts = ($signed(a) < $signed(b));
      e.res = 64'(e.lts);
      return e;
    end
    if (op > 3'd5) return e;
    decode(a, fmt, an, as, av, asg);
    decode(b, fmt, bn, bs, bv, bsg);
    case (op)
      3'd1: begin e.res = 64'(!an && !bn && (av == bv)); e.nv = as || bs; end
      3'd2: begin e.res = 64'(!an && !bn && (av <  bv)); e.nv = an || bn; end
      3'd3: begin e.res = 64'(!an && !bn && (av <= bv)); e.nv = an || bn; end
      default: begin
        e.nv = as || bs;
        if (an && bn)  e.res = fmt ? QNAN_D : QNAN_S;
        else if (an)   e.res = b;
        else if (bn)   e.res = a;
        else begin
          a_less = (av < bv) || ((av == bv) && asg && !bsg);
          b_less = (bv < av) || ((av == bv) && bsg && !asg);
          if (op == 3'd4) e.res = a_less ? a : b;
          else            e.res = b_less ? a : b;
        end
        if (!fmt) e.res[63:32] = 32'hFFFF_FFFF;
      end
    endcase
    return e;
  endfunction

  function automatic logic [63:0] rand_operand(input logic fmt);
    logic [63:0] r;
    logic s;
    int k;
    s = 1'($urandom_range(0, 1));
    k = $urandom_range(0, 9);
    r = {$urandom, $urandom};
    if (fmt == 1'b0) begin
      case (k)
        0: ;
        1: r[31:0] = {s, 31'd0};
        2: r[31:0] = {s, 8'hFF, 1'b1, 22'($urandom)};
        3: r[31:0] = {s, 8'hFF, 1'b0, 22'($urandom | 1)};
        4: r[31:0] = {s, 8'hFF, 23'd0};
        5: r[31:0] = {s, 8'd0, 23'($urandom)};
        6: r[31:0] = {s, 8'd127, 23'($urandom_range(0, 3))};
        default: r[31:0] = {s, 8'($urandom_range(1, 254)), 23'($urandom)};
      endcase
      if (k != 0) r[63:32] = 32'hFFFF_FFFF;
    end else begin
      case (k)
        0: ;
        1: r = {s, 63'd0};
        2: r = {s, 11'h7FF, 1'b1, 51'({$urandom, $urandom})};
        3: r = {s, 11'h7FF, 1'b0, 51'({$urandom, $urandom} | 64'd1)};
        4: r = {s, 11'h7FF, 52'd0};
        5: r = {s, 11'd0, 52'({$urandom, $urandom})};
        6: r = {s, 11'd1023, 52'($urandom_range(0, 3))};
        default: r = {s, 11'($urandom_range(1, 2046)), 52'({$urandom, $urandom})};
      endcase
    end
    return r;
  endfunction

  // Present one op until accepted; expectation is queued on the accepting cycle
  task automatic issue(input logic [2:0] op, input logic fmt, input logic [63:0] a,
                       input logic [63:0] b, input exp_t exp);
    bit acc;
    int budget;
    budget = 200;
    op_i = op; fmt_i = fmt; a_i = a; b_i = b; in_valid_i = 1'b1;
    forever begin
      @(negedge clk);
      acc = in_ready_o;
      if (acc) begin
        sb_q.push_back(exp);
        n_accepted++;
      end
      @(posedge clk); #1;
      if (rand_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
      if (acc) break;
      budget--;
      if (budget == 0) begin
        check("accept_timeout", 64'(in_ready_o), 64'd1);
        break;
      end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic issue_m(input logic [2:0] op, input logic fmt, input logic [63:0] a,
                         input logic [63:0] b);
    issue(op, fmt, a, b, model(op, fmt, a, b));
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_rdy = 1'b0;
    out_ready_i = 1'b1;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 64'(sb_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: stall stability and in-order scoreboard compare on each transfer
  exp_t        e_pop;
  logic [63:0] held_res;
  logic [3:0]  held_flg;
  bit          held_v = 1'b0;
  always @(negedge clk) begin
    if (!rst_n || !out_valid_o) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("stall_result", result_o, held_res);
        check("stall_flags", 64'({eq_o, lt_s_o, lt_u_o, nv_o}), 64'(held_flg));
      end
      if (out_ready_i) begin
        held_v = 1'b0;
        out_count++;
        if (sb_q.size() == 0) begin
          check("unexpected_output", 64'd1, 64'd0);
        end else begin
          e_pop = sb_q.pop_front();
          check("result", result_o, e_pop.res);
          check("flags", 64'({eq_o, lt_s_o, lt_u_o, nv_o}),
                64'({e_pop.eq, e_pop.lts, e_pop.ltu, e_pop.nv}));
        end
      end else begin
        held_v   = 1'b1;
        held_res = result_o;
        held_flg = {eq_o, lt_s_o, lt_u_o, nv_o};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int oc0, na0;
    logic f;
    logic [63:0] a, b;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_flags", 64'({eq_o, lt_s_o, lt_u_o, nv_o}), 64'd0);
    check("rst_in_ready", 64'(in_ready_o), 64'd1);

    // Integer compare with latency check
    issue(3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, mk(64'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    check("lat_cycle1", 64'(out_valid_o), 64'd0);
    @(posedge clk); #1;
    check("lat_cycle2", 64'(out_valid_o), 64'd1);
    drain();

    // Directed FP corner cases with hand-derived expectations
    issue(3'd2, 1'b0, 64'hFFFF_FFFF_7FA0_0000, 64'hFFFF_FFFF_3F80_0000, mk(64'd0, 0, 0, 0, 1));
    issue(3'd1, 1'b0, 64'hFFFF_FFFF_7FC0_0000, 64'hFFFF_FFFF_3F80_0000, mk(64'd0, 0, 0, 0, 0));
    issue(3'd4, 1'b1, 64'h8000_0000_0000_0000, 64'd0, mk(64'h8000_0000_0000_0000, 0, 0, 0, 0));
    issue(3'd5, 1'b1, QNAN_D, QNAN_D, mk(QNAN_D, 0, 0, 0, 0));
    issue(3'd1, 1'b0, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_3F80_0000, mk(64'd0, 0, 0, 0, 0));
    issue(3'd5, 1'b0, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_3F80_0000,
          mk(64'hFFFF_FFFF_3F80_0000, 0, 0, 0, 0));
    issue(3'd3, 1'b0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_0000_0000, mk(64'd1, 0, 0, 0, 0));
    issue(3'd2, 1'b0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_0000_0000, mk(64'd0, 0, 0, 0, 0));
    issue(3'd4, 1'b0, 64'hFFFF_FFFF_7F80_0001, 64'hFFFF_FFFF_C000_0000,
          mk(64'hFFFF_FFFF_C000_0000, 0, 0, 0, 1));
    issue(3'd6, 1'b1, 64'd5, 64'd5, mk(64'd0, 0, 0, 0, 0));
    issue(3'd0, 1'b0, 64'd7, 64'd7, mk(64'd0, 1, 0, 0, 0));
    issue(3'd0, 1'b0, 64'd1, 64'h8000_0000_0000_0000, mk(64'd0, 0, 0, 1, 0));
    drain();

    // Backpressure: four back-to-back ops with the consumer stalled for three cycles
    out_ready_i = 1'b0;
    oc0 = out_count;
    na0 = n_accepted;
    fork
      begin
        for (int i = 0; i < 4; i++) issue_m(3'd0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
      end
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_in_ready", 64'(in_ready_o), 64'd0);
        check("bp_accepted", 64'(n_accepted - na0), 64'd2);
        @(posedge clk); #1;
        out_ready_i = 1'b1;
      end
    join
    drain();
    check("bp_count", 64'(out_count - oc0), 64'd4);

    // Flush with two ops in flight and a competing input
    out_ready_i = 1'b0;
    issue_m(3'd0, 1'b0, 64'd3, 64'd9);
    issue_m(3'd0, 1'b0, 64'd9, 64'd3);
    oc0 = out_count;
    flush_i = 1'b1;
    in_valid_i = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    sb_q.delete();
    check("flush_out_valid", 64'(out_valid_o), 64'd0);
    out_ready_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("flush_no_output", 64'(out_count - oc0), 64'd0);

    // Reset pulse mid-stream
    out_ready_i = 1'b0;
    issue_m(3'd0, 1'b0, 64'd1, 64'd2);
    issue_m(3'd5, 1'b1, 64'd4, 64'd8);
    oc0 = out_count;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete();
    check("mrst_out_valid", 64'(out_valid_o), 64'd0);
    check("mrst_result", result_o, 64'd0);
    check("mrst_flags", 64'({eq_o, lt_s_o, lt_u_o, nv_o}), 64'd0);
    check("mrst_in_ready", 64'(in_ready_o), 64'd1);
    out_ready_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("mrst_no_output", 64'(out_count - oc0), 64'd0);

    // Randomized traffic with random consumer backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      f = 1'($urandom_range(0, 1));
      a = rand_operand(f);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = f ? (a ^ 64'h8000_0000_0000_0000) : (a ^ 64'h0000_0000_8000_0000);
        default: b = rand_operand(f);
      endcase
      issue_m(3'($urandom_range(0, 7)), f, a, b);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/compare_unit.md
Name: compare_unit

Overview:
- Pipelined, parametrised successor of the combinational integer comparator.
- Adds IEEE-754 single/double compare and min/max (FEQ/FLT/FLE/FMIN/FMAX) with RISC-V NaN semantics.
- Adds a valid/ready handshake, backpressure and flush.
- Sits in the execute stage of the RV64F core and serves both the integer branch/SLT path and the FP compare path.

Parameters:
- DATA_W, 64, operand width; legal values 32 or 64. Double format is only available when DATA_W=64.
- FP_EN, 1, when 0 the FP ops are illegal: they produce result 0 and set the NV flag.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush_i  in  1  drops all in-flight ops
- in_valid_i  in  1  input op valid
- in_ready_o  out  1  unit can accept an op
- op_i  in  3  operation: CMP_INT=0, FEQ=1, FLT=2, FLE=3, FMIN=4, FMAX=5
- fmt_i  in  1  FP format: 0=single, 1=double
- a_i, b_i  in  DATA_W  operands
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- result_o  out  DATA_W  0/1 for compares, selected value for min/max
- eq_o, lt_s_o, lt_u_o  out  1  integer flags, valid for CMP_INT; 0 for all other ops
- nv_o  out  1  invalid-operation exception flag

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all valids cleared; out_valid_o=0; result_o=0; all flags=0.
  - in_ready_o=1 from the first cycle after reset release.
- Pipeline: two register stages.
  - S1 captures operands and op, and classifies them: NaN, sNaN, zero, sign, unboxed.
  - S2 holds the final result. Latency is 2 cycles from accept to out_valid_o when out_ready_i=1.
  - Throughput is 1 op/cycle.
- Handshake:
  - Transfer occurs on valid&ready.
  - S2 loads when empty or when out_ready_i=1.
  - S1 advances when S2 loads.
  - in_ready_o = (!s1_valid | s1_advance) & !flush_i.
  - While out_valid_o=1 and out_ready_i=0, outputs are held stable.
- flush_i clears both stage valids at the next edge. An input presented in the same cycle is not accepted.
- rst_n low mid-operation discards everything, identical to flush.
- CMP_INT:
  - eq = a==b; lt_u = unsigned a<b; lt_s = two's-complement a<b.
  - result_o = {0, lt_s}. nv_o=0.
- Single format (fmt_i=0):
  - Operand is the low 32 bits.
  - If DATA_W=64 and the upper 32 bits are not all ones, the operand is treated as canonical quiet NaN (NaN-boxing).
- Double format:
  - fmt_i=1 with DATA_W=32 is illegal: result 0, nv_o=1.
- FEQ:
  - result 1 iff neither operand is NaN and the values are equal; -0 == +0.
  - nv_o=1 only if either operand is sNaN.
- FLT/FLE:
  - any NaN operand gives result 0 and nv_o=1.
  - otherwise a strict/non-strict ordered compare, with -0 == +0.
- FMIN/FMAX:
  - -0 is less than +0.
  - Exactly one NaN: return the other operand.
  - Both NaN: return canonical NaN (single: 0xFFFFFFFF_7FC00000 NaN-boxed; double: 0x7FF8_0000_0000_0000).
  - nv_o=1 if either operand is sNaN.
  - A single-precision result is NaN-boxed (upper 32 bits = all ones).
- Undefined op codes (6, 7): result 0, all flags 0, nv_o=0.

Decomposition:
- Package cmp_pkg holds:
  - op enum cmp_op_e
  - fmt enum
  - canonical NaN constants CNAN_S, CNAN_D
  - struct fp_class_t {is_nan, is_snan, is_zero, sign}
- One sub-module, fp_classify: combinational, format-aware classification including the NaN-box check. It is instantiated twice in S1.

Test Plan:
- CMP_INT, a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> eq=0, lt_u=0, lt_s=1, result=1, out_valid_o exactly 2 cycles after accept.
- FLT single, a=0xFFFFFFFF_7FA00000 (sNaN), b=0xFFFFFFFF_3F800000 -> result=0, nv_o=1. FEQ with a=qNaN 0xFFFFFFFF_7FC00000 -> result=0, nv_o=0.
- FMIN double, a=0x8000_0000_0000_0000 (-0), b=0 -> result=0x8000_0000_0000_0000. FMAX with both qNaN -> 0x7FF8_0000_0000_0000, nv_o=0.
- Single NaN-box: a=0x0000_0000_3F80_0000, b=0xFFFFFFFF_3F800000, FEQ -> result=0. FMAX of the same operands -> result=0xFFFFFFFF_3F800000.
- Backpressure: stream 4 back-to-back CMP_INT ops with out_ready_i low for 3 cycles ->
  - in_ready_o drops after 2 ops are accepted;
  - outputs stay stable while stalled;
  - all 4 results emerge in order, with no loss or duplication.
- Flush and reset:
  - flush_i while 2 ops are in flight -> out_valid_o=0 next cycle and the flushed ops never appear.
  - rst_n=0 for one cycle mid-stream -> all outputs 0, in_ready_o=1 after release.
